// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_rx_pkg;

   localparam int MIN_DATA_BITS      = 5;
   // Width of the data field carried through the receive FIFO.
   localparam int ENTRY_DATA_W       = 9;
   localparam int DEFAULT_OVERSAMPLE = 16;
   // Centre sample tick of a bit for the default oversample rate.
   localparam int VOTE_MID           = DEFAULT_OVERSAMPLE / 2;

   // Centre sample tick for an arbitrary (even) oversample rate.
   function automatic int vote_mid(input int oversample);
      return oversample / 2;
   endfunction

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2
   } rx_state_t;

   typedef struct packed {
      logic [ENTRY_DATA_W-1:0] data;
      logic                    parity_err;
      logic                    framing_err;
      logic                    brk;
   } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received frames; entry type is a parameter.
module uart_rx_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   // Pointer/count update; a push into a full FIFO only lands if a pop frees a slot.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage and pointer registers; reset flushes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_push) mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, sample-tick generator, framing FSM and output FIFO.
module uart_rx_core
   import uart_rx_pkg::*;
#(
   parameter int MAX_DATA_BITS = ENTRY_DATA_W,
   parameter int OVERSAMPLE    = 16,
   parameter int DIV_W         = 12,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_in,
   input  logic [DIV_W-1:0]         baud_divisor,
   input  logic [3:0]               data_len,
   input  logic                     parity_en,
   input  logic                     parity_odd,
   input  logic                     two_stop_bits,
   input  logic                     rx_enable,
   output logic [MAX_DATA_BITS-1:0] rx_data,
   output logic                     rx_parity_err,
   output logic                     rx_framing_err,
   output logic                     rx_break,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic                     overrun,
   output logic                     busy
);

   localparam int M   = vote_mid(OVERSAMPLE);
   localparam int OSW = $clog2(OVERSAMPLE);

   rx_state_t state_q, state_d;

   logic                     sync1_q, rx_s_q, rx_prev_q;
   logic [DIV_W-1:0]         tick_cnt_q, tick_cnt_d, div_m1;
   logic [OSW-1:0]           os_cnt_q, os_cnt_d;
   logic                     v0_q, v0_d, v1_q, v1_d;
   logic [MAX_DATA_BITS-1:0] data_q, data_d;
   logic [3:0]               bit_idx_q, bit_idx_d;
   logic [3:0]               len_q, len_d, len_clamped;
   logic                     par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
   logic                     perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
   logic                     overrun_q, overrun_d;
   logic                     tick, start_det, decide, voted, push;
   logic                     fifo_full, fifo_empty;
   rx_entry_t                push_entry, head;

   // Tick generator, oversample sub-counter and mid-bit vote capture.
   always_comb begin
      div_m1    = (baud_divisor == '0) ? '0 : baud_divisor - 1'b1;
      tick      = (tick_cnt_q == '0);
      start_det = (state_q == IDLE) && rx_enable && !rx_s_q && rx_prev_q;
      decide    = tick && (state_q != IDLE) && (os_cnt_q == OSW'(M + 1));
      voted     = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
      if (start_det)  tick_cnt_d = '0;
      else if (tick)  tick_cnt_d = div_m1;
      else            tick_cnt_d = tick_cnt_q - 1'b1;
      if (start_det)  os_cnt_d = '0;
      else if (tick)  os_cnt_d = (os_cnt_q == OSW'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + 1'b1;
      else            os_cnt_d = os_cnt_q;
      v0_d = (tick && os_cnt_q == OSW'(M - 1)) ? rx_s_q : v0_q;
      v1_d = (tick && os_cnt_q == OSW'(M))     ? rx_s_q : v1_q;
   end

   // Clamp the requested data length into the supported range.
   always_comb begin
      len_clamped = data_len;
      if (data_len < 4'(MIN_DATA_BITS))      len_clamped = 4'(MIN_DATA_BITS);
      else if (data_len > 4'(MAX_DATA_BITS)) len_clamped = 4'(MAX_DATA_BITS);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; every move past IDLE happens on a bit decision tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (start_det) state_d = START;
         START:  if (decide) state_d = voted ? IDLE : DATA;
         DATA:   if (decide && bit_idx_q == len_q - 4'd1) state_d = par_en_q ? PARITY : STOP1;
         PARITY: if (decide) state_d = STOP1;
         STOP1:  if (decide) state_d = two_stop_q ? STOP2 : IDLE;
         STOP2:  if (decide) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: config latch, data shift, error accumulation and the push strobe.
   always_comb begin
      data_d     = data_q;
      bit_idx_d  = bit_idx_q;
      len_d      = len_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      two_stop_d = two_stop_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = brk_q;
      push       = 1'b0;
      case (state_q)
         IDLE: if (start_det) begin
            data_d     = '0;
            bit_idx_d  = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            brk_d      = 1'b1;
            len_d      = len_clamped;
            par_en_d   = parity_en;
            par_odd_d  = parity_odd;
            two_stop_d = two_stop_bits;
         end
         DATA: if (decide) begin
            data_d[bit_idx_q] = voted;
            bit_idx_d         = bit_idx_q + 4'd1;
            brk_d             = brk_q & ~voted;
         end
         PARITY: if (decide) begin
            perr_d = voted != ((^data_q) ^ par_odd_q);
            brk_d  = brk_q & ~voted;
         end
         STOP1: if (decide) begin
            // A low stop bit is a framing error; with all-low bits it is a break too.
            ferr_d = ferr_q | ~voted;
            brk_d  = brk_q & ~voted;
            push   = !two_stop_q;
         end
         STOP2: if (decide) begin
            ferr_d = ferr_q | ~voted;
            push   = 1'b1;
         end
         default: ;
      endcase
      push_entry.data        = ENTRY_DATA_W'(data_d);
      push_entry.parity_err  = perr_d;
      push_entry.framing_err = ferr_d;
      push_entry.brk         = brk_d;
      overrun_d = push && fifo_full && !(rx_ready && !fifo_empty);
   end

   // Synchroniser, tick counters and frame datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_prev_q  <= 1'b1;
         tick_cnt_q <= '0;
         os_cnt_q   <= '0;
         v0_q       <= 1'b1;
         v1_q       <= 1'b1;
         data_q     <= '0;
         bit_idx_q  <= '0;
         len_q      <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sync1_q    <= rx_in;
         rx_s_q     <= sync1_q;
         rx_prev_q  <= rx_s_q;
         tick_cnt_q <= tick_cnt_d;
         os_cnt_q   <= os_cnt_d;
         v0_q       <= v0_d;
         v1_q       <= v1_d;
         data_q     <= data_d;
         bit_idx_q  <= bit_idx_d;
         len_q      <= len_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         two_stop_q <= two_stop_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
         overrun_q  <= overrun_d;
      end
   end

   uart_rx_fifo #(.T(rx_entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_entry),
      .pop   (rx_ready),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_data        = MAX_DATA_BITS'(head.data);
   assign rx_parity_err  = head.parity_err;
   assign rx_framing_err = head.framing_err;
   assign rx_break       = head.brk;
   assign rx_valid       = !fifo_empty;
   assign overrun        = overrun_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame-level model plus per-cycle head compare.
module tb_uart_rx_core;

   localparam int BIT = 32;  // baud_divisor 2 x 16 ticks

   typedef struct {
      logic [8:0] d;
      bit         pe;
      bit         fe;
      bit         br;
   } exp_t;

   logic        clk = 1'b0, reset = 1'b1, rx_in = 1'b1;
   logic [11:0] baud_divisor = 12'd2;
   logic [3:0]  data_len = 4'd8;
   logic        parity_en = 1'b0, parity_odd = 1'b0, two_stop_bits = 1'b0;
   logic        rx_enable = 1'b1, rx_ready = 1'b0;
   logic [8:0]  rx_data;
   logic        rx_parity_err, rx_framing_err, rx_break, rx_valid, overrun, busy;

   int   n_checks = 0, n_fail = 0, cyc = 0;
   int   ovr_seen = 0, exp_ovr = 0, frame_start_cyc = 0;
   exp_t mfifo[$];

   uart_rx_core dut (
      .clk(clk), .reset(reset), .rx_in(rx_in), .baud_divisor(baud_divisor),
      .data_len(data_len), .parity_en(parity_en), .parity_odd(parity_odd),
      .two_stop_bits(two_stop_bits), .rx_enable(rx_enable), .rx_data(rx_data),
      .rx_parity_err(rx_parity_err), .rx_framing_err(rx_framing_err), .rx_break(rx_break),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // What a frame must decode to, from the line bits that were sent.
   function automatic exp_t expect_frame(input logic [8:0] d, input int len, input bit pe,
                                         input bit po, input bit pbit, input bit s1,
                                         input bit s2, input bit two);
      exp_t e;
      logic [8:0] m;
      m    = d & 9'((1 << len) - 1);
      e.d  = m;
      e.pe = pe && (pbit != ((^m) ^ po));
      e.br = (m == 0) && (!pe || !pbit) && !s1;
      e.fe = !s1 || (two && !s2);
      return e;
   endfunction

   task automatic model_push(input exp_t e);
      if (mfifo.size() >= 4) exp_ovr++;
      else mfifo.push_back(e);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [8:0] d, input int len, input bit pe, input bit po,
                             input bit pbit, input bit s1, input bit s2, input bit two);
      @(posedge clk); #1;
      frame_start_cyc = cyc;
      rx_in = 1'b0; wait_clks(BIT);
      for (int i = 0; i < len; i++) begin rx_in = d[i]; wait_clks(BIT); end
      if (pe) begin rx_in = pbit; wait_clks(BIT); end
      rx_in = s1;
      if (two) begin wait_clks(BIT); rx_in = s2; end
      // Model entry appears mid last stop bit, a few cycles ahead of the DUT's push.
      wait_clks(BIT / 2);
      model_push(expect_frame(d, len, pe, po, pbit, s1, s2, two));
      wait_clks(BIT / 2);
      rx_in = 1'b1;
   endtask

   function automatic bit par8(input logic [8:0] d, input int len, input bit odd);
      return (^(d & 9'((1 << len) - 1))) ^ odd;
   endfunction

   task automatic read_entry(input string name, output logic [8:0] d, output logic pe,
                             output logic fe, output logic br);
      int k = 0;
      @(negedge clk);
      while (!rx_valid && k < 3000) begin @(negedge clk); k++; end
      chk({name, "_valid"}, int'(rx_valid), 1);
      d = rx_data; pe = rx_parity_err; fe = rx_framing_err; br = rx_break;
      if (rx_valid) begin
         @(posedge clk); #1 rx_ready = 1'b1;
         @(posedge clk); #1 rx_ready = 1'b0;
      end
   endtask

   // Head of FIFO must always match the model while it is presented.
   always @(negedge clk) begin
      if (!reset) begin
         if (overrun) ovr_seen++;
         chk("valid_without_expected_entry", int'(rx_valid && mfifo.size() == 0), 0);
         if (rx_valid && mfifo.size() > 0) begin
            chk("model_data", int'(rx_data), int'(mfifo[0].d));
            chk("model_perr", int'(rx_parity_err), int'(mfifo[0].pe));
            chk("model_ferr", int'(rx_framing_err), int'(mfifo[0].fe));
            chk("model_brk",  int'(rx_break), int'(mfifo[0].br));
            if (rx_ready) void'(mfifo.pop_front());
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] d;
      logic pe, fe, br;
      int lat, k;

      // Reset state
      wait_clks(3);
      @(negedge clk);
      chk("rst_data", int'(rx_data), 0);
      chk("rst_flags", int'({rx_parity_err, rx_framing_err, rx_break}), 0);
      chk("rst_valid", int'(rx_valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk); #1 reset = 1'b0;
      wait_clks(10);

      // 1: 8N1 0xA5 and push latency relative to the start edge
      lat = 0;
      fork
         send_frame(9'h0A5, 8, 0, 0, 0, 1, 1, 0);
         begin
            k = 0;
            @(negedge clk);
            while (!rx_valid && k < 600) begin @(negedge clk); k++; end
            lat = cyc - frame_start_cyc;
         end
      join
      chk("t1_latency", lat, 310);
      read_entry("t1", d, pe, fe, br);
      chk("t1_data", int'(d), 'h0A5);
      chk("t1_flags", int'({pe, fe, br}), 0);

      // 2: 7E2, 0x41 with wrong parity bit; config inputs change mid-frame
      data_len = 4'd7; parity_en = 1'b1; parity_odd = 1'b0; two_stop_bits = 1'b1;
      fork
         send_frame(9'h041, 7, 1, 0, 1, 1, 1, 1);
         begin wait_clks(100); data_len = 4'd5; parity_en = 1'b0; two_stop_bits = 1'b0; parity_odd = 1'b1; end
      join
      read_entry("t2", d, pe, fe, br);
      chk("t2_data", int'(d), 'h041);
      chk("t2_perr", int'(pe), 1);
      chk("t2_ferr", int'(fe), 0);

      // 3: 6-tick (12 clk) low glitch rejected as a false start
      data_len = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; two_stop_bits = 1'b0;
      @(posedge clk); #1 rx_in = 1'b0;
      wait_clks(4);
      chk("t3_busy_during", int'(busy), 1);
      wait_clks(8); rx_in = 1'b1;
      wait_clks(40);
      chk("t3_busy_after", int'(busy), 0);
      chk("t3_no_entry", int'(rx_valid), 0);
      send_frame(9'h03C, 8, 0, 0, 0, 1, 1, 0);
      read_entry("t3", d, pe, fe, br);
      chk("t3_data", int'(d), 'h03C);

      // 4: five frames with no reader; the fifth overruns
      ovr_seen = 0; exp_ovr = 0;
      for (int f = 1; f <= 4; f++) send_frame(9'(f), 8, 0, 0, 0, 1, 1, 0);
      wait_clks(4);
      chk("t4_no_early_overrun", ovr_seen, 0);
      send_frame(9'h005, 8, 0, 0, 0, 1, 1, 0);
      wait_clks(4);
      chk("t4_overrun_once", ovr_seen, 1);
      chk("t4_overrun_model", ovr_seen, exp_ovr);
      for (int f = 1; f <= 4; f++) begin
         read_entry("t4", d, pe, fe, br);
         chk("t4_order", int'(d), f);
      end
      @(negedge clk);
      chk("t4_drained", int'(rx_valid), 0);

      // 5: 9-bit data with bad second stop, then a break, then a clamped length
      data_len = 4'd9; two_stop_bits = 1'b1;
      send_frame(9'h1A3, 9, 0, 0, 0, 1, 0, 1);
      read_entry("t5a", d, pe, fe, br);
      chk("t5a_data", int'(d), 'h1A3);
      chk("t5a_ferr", int'(fe), 1);
      chk("t5a_brk", int'(br), 0);
      data_len = 4'd8; two_stop_bits = 1'b0;
      send_frame(9'h000, 8, 0, 0, 0, 0, 0, 0);
      read_entry("t5b", d, pe, fe, br);
      chk("t5b_brk", int'(br), 1);
      chk("t5b_ferr", int'(fe), 1);
      data_len = 4'd3; parity_en = 1'b1; parity_odd = 1'b1;
      send_frame(9'h015, 5, 1, 1, par8(9'h015, 5, 1), 1, 1, 0);
      read_entry("t5c", d, pe, fe, br);
      chk("t5c_data", int'(d), 'h015);
      chk("t5c_perr", int'(pe), 0);
      data_len = 4'd8; parity_en = 1'b0; parity_odd = 1'b0;

      // 6: reset during DATA bit 3 with an unread entry pending
      send_frame(9'h077, 8, 0, 0, 0, 1, 1, 0);
      wait_clks(10);
      @(posedge clk); #1 rx_in = 1'b0;
      wait_clks(BIT);
      for (int i = 0; i < 3; i++) begin rx_in = d[i]; wait_clks(BIT); end
      rx_in = 1'b1; wait_clks(BIT / 2);
      chk("t6_busy_before", int'(busy), 1);
      chk("t6_pending_entry", int'(rx_valid), 1);
      reset = 1'b1; mfifo.delete();
      @(posedge clk); #1 reset = 1'b0;
      chk("t6_busy_after_rst", int'(busy), 0);
      chk("t6_valid_after_rst", int'(rx_valid), 0);
      wait_clks(40);
      send_frame(9'h05A, 8, 0, 0, 0, 1, 1, 0);
      read_entry("t6", d, pe, fe, br);
      chk("t6_data", int'(d), 'h05A);
      chk("t6_flags", int'({pe, fe, br}), 0);

      wait_clks(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
